// File: rtl/tea_pkg.sv
// rtl/tea_pkg.sv - shared constants, header helper and FSM state type for the TEA framer
package tea_pkg;

    localparam logic [31:0] PDF_PLAIN_HEADER_1     = 32'h2550_4446;
    localparam logic [31:0] PDF_PLAIN_HEADER_2     = 32'h2d31_2e36;
    localparam logic [31:0] PDF_ENCRYPTED_HEADER_1 = 32'h42c3_7893;
    localparam logic [31:0] PDF_ENCRYPTED_HEADER_2 = 32'hfbc2_d912;
    localparam logic [31:0] DELTA                  = 32'h9e37_79b9;
    localparam logic [31:0] DECRYPT_SUM_0          = 32'hc6ef_3720;

    typedef enum logic [1:0] {IDLE, FILL, FLUSH} state_t;

    // Encrypting consumes plaintext, so it expects the plain "%PDF-1.6" header.
    function automatic logic [63:0] hdr_const(input logic encrypt);
        return encrypt ? {PDF_PLAIN_HEADER_1, PDF_PLAIN_HEADER_2}
                       : {PDF_ENCRYPTED_HEADER_1, PDF_ENCRYPTED_HEADER_2};
    endfunction

endpackage

// File: rtl/tea_hdr_check.sv
// rtl/tea_hdr_check.sv - registered first-block header compare, result aligned with blk_valid
module tea_hdr_check
    import tea_pkg::*;
#(
    parameter bit CHECK_HDR = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic        load,
    input  logic        first,
    input  logic        encrypt,
    input  logic [63:0] data,
    input  logic [2:0]  pad,
    output logic        hdr_valid,
    output logic        hdr_ok
);

    logic pend;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend   <= 1'b0;
            hdr_ok <= 1'b0;
        end else if (ena) begin
            pend <= CHECK_HDR && load && first;
            if (load && first)
                hdr_ok <= CHECK_HDR && (pad == 3'd0) && (data == hdr_const(encrypt));
        end
    end

    // A pending pulse is held off while ena is low.
    assign hdr_valid = pend && ena;

endmodule

// File: rtl/tea_block_packer.sv
// rtl/tea_block_packer.sv - packs a byte stream into 64-bit TEA blocks with padding and mode latch
module tea_block_packer
    import tea_pkg::*;
#(
    parameter bit         MSB_FIRST = 1'b1,
    parameter logic [7:0] PAD_BYTE  = 8'h00,
    parameter bit         CHECK_HDR = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic        encrypt,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [63:0] blk_data,
    output logic        blk_valid,
    output logic        blk_last,
    output logic [2:0]  blk_pad,
    output logic        blk_encrypt,
    output logic        hdr_valid,
    output logic        hdr_ok
);

    state_t      state, state_nxt;
    logic [2:0]  cnt;
    logic [55:0] sh;
    logic        mode_q, first_q, blk_pend;
    logic        accept, complete, cur_mode, is_first;
    logic [63:0] full, msb_blk, lane_blk;

    assign in_ready = ena && (state != FLUSH);
    assign accept   = in_valid && in_ready;
    assign complete = accept && ((cnt == 3'd7) || in_last);
    assign cur_mode = (state == IDLE) ? encrypt : mode_q;
    assign is_first = (state == IDLE) || first_q;
    assign full     = {sh, in_data};

    // Byte j of the block (arrival order) lands in the j-th most significant lane.
    always_comb begin
        msb_blk  = '0;
        lane_blk = '0;
        for (int j = 0; j < 8; j++) begin
            if (j <= int'(cnt))
                msb_blk[63-8*j -: 8] = full[8*(int'(cnt)-j) +: 8];
            else
                msb_blk[63-8*j -: 8] = PAD_BYTE;
        end
        for (int j = 0; j < 8; j++)
            lane_blk[8*j +: 8] = msb_blk[63-8*j -: 8];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = in_last ? FLUSH : FILL;
            FILL:    if (accept && in_last) state_nxt = FLUSH;
            FLUSH:   if (ena) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt         <= 3'd0;
            sh          <= '0;
            mode_q      <= 1'b0;
            first_q     <= 1'b0;
            blk_pend    <= 1'b0;
            blk_data    <= '0;
            blk_last    <= 1'b0;
            blk_pad     <= 3'd0;
            blk_encrypt <= 1'b0;
        end else begin
            if (ena)
                blk_pend <= complete;
            if (accept) begin
                cnt     <= complete ? 3'd0 : cnt + 3'd1;
                sh      <= complete ? '0 : {sh[47:0], in_data};
                first_q <= is_first && !complete;
                if (state == IDLE)
                    mode_q <= encrypt;
            end
            if (complete) begin
                blk_data    <= MSB_FIRST ? msb_blk : lane_blk;
                blk_last    <= in_last;
                blk_pad     <= 3'd7 - cnt;
                blk_encrypt <= cur_mode;
            end
        end
    end

    assign blk_valid = blk_pend && ena;

    tea_hdr_check #(.CHECK_HDR(CHECK_HDR)) u_hdr_check (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .load      (complete),
        .first     (is_first),
        .encrypt   (cur_mode),
        .data      (msb_blk),
        .pad       (3'd7 - cnt),
        .hdr_valid (hdr_valid),
        .hdr_ok    (hdr_ok)
    );

endmodule

// File: tb/tb_tea_block_packer.sv
// tb/tb_tea_block_packer.sv - randomized and directed bench for tea_block_packer against a message-level model
module tb_tea_block_packer;

    localparam logic [63:0] PLAIN = 64'h2550_4446_2d31_2e36;
    localparam logic [63:0] ENCH  = 64'h42c3_7893_fbc2_d912;

    logic        clk = 1'b0;
    logic        rst, ena, encrypt, in_valid, in_last, in_ready;
    logic [7:0]  in_data;
    logic [63:0] blk_data;
    logic        blk_valid, blk_last, blk_encrypt, hdr_valid, hdr_ok;
    logic [2:0]  blk_pad;

    always #5 clk = ~clk;

    tea_block_packer dut (
        .clk(clk), .rst(rst), .ena(ena), .encrypt(encrypt),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .blk_data(blk_data), .blk_valid(blk_valid), .blk_last(blk_last), .blk_pad(blk_pad),
        .blk_encrypt(blk_encrypt), .hdr_valid(hdr_valid), .hdr_ok(hdr_ok)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [63:0] data;
        logic        last;
        logic [2:0]  pad;
        logic        enc;
        logic        first;
        logic        hok;
    } blk_t;

    blk_t        exp_q[$];
    logic [7:0]  cur[$];
    logic        cur_enc = 1'b0;
    bit          first_pend = 0, in_msg = 0;

    // Message-level model: collect bytes, cut a block at 8 bytes or at the last byte.
    function automatic void model_emit(input logic last);
        blk_t e;
        e.data = '0;
        for (int i = 0; i < 8; i++)
            e.data = {e.data[55:0], (i < cur.size()) ? cur[i] : 8'h00};
        e.pad   = 3'(8 - cur.size());
        e.last  = last;
        e.enc   = cur_enc;
        e.first = first_pend;
        e.hok   = first_pend && (e.pad == 3'd0) && (e.data == (cur_enc ? PLAIN : ENCH));
        exp_q.push_back(e);
        first_pend = 0;
        cur.delete();
    endfunction

    function automatic void model_accept(input logic [7:0] b, input logic last, input logic enc);
        if (!in_msg) begin
            in_msg     = 1;
            cur_enc    = enc;
            first_pend = 1;
        end
        cur.push_back(b);
        if (cur.size() == 8 || last) model_emit(last);
        if (last) in_msg = 0;
    endfunction

    int          nblk = 0;
    logic [63:0] seen_data = '0;
    logic [2:0]  seen_pad = '0;
    logic        seen_last = 0, seen_enc = 0, seen_hv = 0, seen_hok = 0;
    blk_t        mon_e;

    always @(negedge clk) begin
        if (rst === 1'b1 && blk_valid === 1'b1) begin
            nblk++;
            seen_data = blk_data; seen_pad = blk_pad; seen_last = blk_last;
            seen_enc = blk_encrypt; seen_hv = hdr_valid; seen_hok = hdr_ok;
            if (exp_q.size() == 0) begin
                chk("unexpected_blk", blk_valid, 1'b0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("blk_data", blk_data, mon_e.data);
                chk("blk_last", blk_last, mon_e.last);
                chk("blk_pad", blk_pad, mon_e.pad);
                chk("blk_encrypt", blk_encrypt, mon_e.enc);
                chk("hdr_valid", hdr_valid, mon_e.first);
                if (mon_e.first) chk("hdr_ok", hdr_ok, mon_e.hok);
            end
        end else if (rst === 1'b1 && hdr_valid === 1'b1) begin
            chk("stray_hdr_valid", hdr_valid, 1'b0);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(input logic [7:0] b, input logic last, input logic enc);
        bit done = 0;
        in_data = b; in_last = last; encrypt = enc; in_valid = 1'b1;
        for (int k = 0; k < 60 && !done; k++) begin
            @(negedge clk);
            if (in_ready) begin
                model_accept(b, last, enc);
                done = 1;
            end
            @(posedge clk); #1;
        end
        if (!done) chk("accept_timeout", in_ready, 1'b1);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic rsend(input logic [7:0] b, input logic last, input logic enc);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        if ($urandom_range(0, 5) == 0) begin ena = 1'b0; idle($urandom_range(1, 2)); ena = 1'b1; end
        send(b, last, enc);
        if ($urandom_range(0, 4) == 0) begin ena = 1'b0; idle($urandom_range(1, 3)); ena = 1'b1; end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_blk_valid"}, blk_valid, 1'b0);
        chk({tag, "_blk_data"}, blk_data, 64'h0);
        chk({tag, "_blk_last"}, blk_last, 1'b0);
        chk({tag, "_blk_pad"}, blk_pad, 3'd0);
        chk({tag, "_blk_encrypt"}, blk_encrypt, 1'b0);
        chk({tag, "_hdr_valid"}, hdr_valid, 1'b0);
        chk({tag, "_hdr_ok"}, hdr_ok, 1'b0);
    endtask

    initial begin
        int          n0, len;
        logic        menc;
        logic        hdrmsg;
        logic [63:0] hc;
        logic [7:0]  b;

        rst = 1'b1; ena = 1'b1; encrypt = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
        #2 rst = 1'b0;
        repeat (2) @(posedge clk); #1;
        chk_reset_outputs("reset");
        rst = 1'b1;
        idle(1);

        // 1: "%PDF-1.6" in encrypt mode
        hc = PLAIN;
        for (int i = 0; i < 8; i++) send(hc[63-8*i -: 8], i == 7, 1'b1);
        idle(2);
        chk("t1_data", seen_data, PLAIN);
        chk("t1_pad", seen_pad, 3'd0);
        chk("t1_last", seen_last, 1'b1);
        chk("t1_hdr_valid", seen_hv, 1'b1);
        chk("t1_hdr_ok", seen_hok, 1'b1);

        // 2: encrypted header then a 3-byte tail
        hc = ENCH;
        for (int i = 0; i < 8; i++) send(hc[63-8*i -: 8], 1'b0, 1'b0);
        idle(1);
        chk("t2_b1_hdr_ok", seen_hok, 1'b1);
        chk("t2_b1_last", seen_last, 1'b0);
        send(8'h11, 1'b0, 1'b0); send(8'h22, 1'b0, 1'b0); send(8'h33, 1'b1, 1'b0);
        idle(2);
        chk("t2_b2_data", seen_data, 64'h1122_3300_0000_0000);
        chk("t2_b2_pad", seen_pad, 3'd5);
        chk("t2_b2_last", seen_last, 1'b1);

        // 3: 16 bytes, encrypt toggled mid-message, valid gaps
        n0 = nblk;
        for (int i = 0; i < 16; i++) begin
            idle($urandom_range(0, 2));
            send(8'(i), i == 15, i < 5);
        end
        idle(2);
        chk("t3_nblk", nblk - n0, 2);
        chk("t3_data", seen_data, 64'h0809_0a0b_0c0d_0e0f);
        chk("t3_enc", seen_enc, 1'b1);

        // 4: single byte; in_ready low only in the flush cycle
        send(8'hAA, 1'b1, 1'b1);
        @(negedge clk); chk("t4_ready_flush", in_ready, 1'b0);
        @(negedge clk); chk("t4_ready_after", in_ready, 1'b1);
        @(posedge clk); #1;
        chk("t4_data", seen_data, 64'hAA00_0000_0000_0000);
        chk("t4_pad", seen_pad, 3'd7);
        chk("t4_hdr_ok", seen_hok, 1'b0);

        // 5: ena low before the 8th byte, then ena low during a pending pulse
        for (int i = 0; i < 7; i++) send(8'h30 + 8'(i), 1'b0, 1'b0);
        in_data = 8'h37; in_last = 1'b1; in_valid = 1'b1; ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_ready_low", in_ready, 1'b0);
            chk("t5_no_blk", blk_valid, 1'b0);
            @(posedge clk); #1;
        end
        ena = 1'b1;
        send(8'h37, 1'b1, 1'b0);
        @(negedge clk); chk("t5_latency", blk_valid, 1'b1);
        @(posedge clk); #1;
        chk("t5_data", seen_data, 64'h3031_3233_3435_3637);
        send(8'h5a, 1'b1, 1'b1);
        ena = 1'b0;
        @(negedge clk); chk("t5_defer_low1", blk_valid, 1'b0);
        @(posedge clk); #1;
        @(negedge clk); chk("t5_defer_low2", blk_valid, 1'b0);
        @(posedge clk); #1;
        ena = 1'b1;
        @(negedge clk); chk("t5_defer_pulse", blk_valid, 1'b1);
        @(posedge clk); #1;
        @(negedge clk); chk("t5_defer_once", blk_valid, 1'b0);
        @(posedge clk); #1;

        // 6: reset after 4 bytes discards the partial block
        for (int i = 0; i < 4; i++) send(8'hc0 + 8'(i), 1'b0, 1'b0);
        rst = 1'b0;
        #1 chk_reset_outputs("t6");
        cur.delete(); in_msg = 0; first_pend = 0;
        idle(2);
        rst = 1'b1;
        idle(4);
        hc = PLAIN;
        for (int i = 0; i < 8; i++) send(hc[63-8*i -: 8], i == 7, 1'b1);
        idle(2);
        chk("t6_data", seen_data, PLAIN);
        chk("t6_hdr_valid", seen_hv, 1'b1);
        chk("t6_hdr_ok", seen_hok, 1'b1);

        // random messages
        for (int m = 0; m < 40; m++) begin
            len    = $urandom_range(1, 20);
            menc   = 1'($urandom_range(0, 1));
            hdrmsg = ($urandom_range(0, 3) == 0);
            hc     = menc ? PLAIN : ENCH;
            for (int i = 0; i < len; i++) begin
                b = (hdrmsg && i < 8) ? hc[63-8*i -: 8] : 8'($urandom_range(0, 255));
                rsend(b, i == len - 1, (i == 0) ? menc : 1'($urandom_range(0, 1)));
            end
        end
        idle(5);
        chk("exp_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
